// File: rtl/dma_bus_arbiter.sv
// DMA bus arbiter: turns a device interrupt into a begin_dma command, runs the br/bg
// handshake against CPU memory activity, and signals completion. Optional watchdog: DMA_ARB_WATCHDOG_EN.
module dma_bus_arbiter #(
  parameter int                   WORD_SIZE   = 16,
  parameter int                   DMA_LENGTH  = 12,
  parameter logic [WORD_SIZE-1:0] DMA_TARGET  = 16'h01F4,
  parameter int                   WDOG_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 dev_irq,
  input  logic                 cpu_mem_busy,
  input  logic                 br,
  output logic                 begin_dma,
  output logic [WORD_SIZE-1:0] length,
  output logic [WORD_SIZE-1:0] target_address,
  output logic                 bg,
  output logic                 cpu_stall,
  output logic                 dma_end_irq,
  output logic                 dma_error,
  output logic [WORD_SIZE-1:0] busy_cycles
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_WAIT_BR = 3'd2,
    S_GRANTED = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic                   r_pending;
  logic [WORD_SIZE-1:0]   r_grant_cnt;
  logic                   r_begin_dma;
  logic                   r_bg;
  logic                   r_cpu_stall;
  logic                   r_end_irq;
  logic [WORD_SIZE-1:0]   r_busy_cycles;

  logic                   w_grant;
  logic                   w_release;
  logic                   w_abort;
  logic                   w_begin_nxt;
  logic                   w_bg_nxt;
  logic                   w_end_nxt;

  if (WDOG_CYCLES < 1) begin : g_wdog_param_chk
    $error("WDOG_CYCLES must be at least 1");
  end

  function automatic logic [WORD_SIZE-1:0] sat_inc(input logic [WORD_SIZE-1:0] v);
    return (&v) ? v : v + WORD_SIZE'(1);
  endfunction

  // The CPU's in-flight memory access always completes before the bus is handed over.
  assign w_grant   = (r_state == S_WAIT_BR) && br && !cpu_mem_busy;
  assign w_release = (r_state == S_GRANTED) && !br;

`ifdef DMA_ARB_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

  logic [WDOG_W-1:0] r_wdog;
  logic              r_dma_error;
  logic              w_wdog_hit;

  // A normal grant or release on the same edge wins over the timeout.
  assign w_wdog_hit = (r_wdog == WDOG_W'(WDOG_CYCLES - 1));
  assign w_abort    = w_wdog_hit &&
                      (((r_state == S_WAIT_BR) && !w_grant) ||
                       ((r_state == S_GRANTED) && !w_release));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wdog      <= '0;
      r_dma_error <= 1'b0;
    end else begin
      r_dma_error <= w_abort;
      if (w_grant || w_abort ||
          ((r_state != S_WAIT_BR) && (r_state != S_GRANTED)))
        r_wdog <= '0;
      else
        r_wdog <= r_wdog + WDOG_W'(1);
    end
  end

  assign dma_error = r_dma_error;
`else
  assign w_abort   = 1'b0;
  assign dma_error = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (dev_irq || r_pending) w_next = S_START;
      S_START:   w_next = S_WAIT_BR;
      S_WAIT_BR: begin
        if (w_abort)      w_next = S_IDLE;
        else if (w_grant) w_next = S_GRANTED;
      end
      S_GRANTED: begin
        if (w_release)    w_next = S_DONE;
        else if (w_abort) w_next = S_IDLE;
      end
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_begin_nxt = (w_next == S_START);
    w_bg_nxt    = (w_next == S_GRANTED);
    w_end_nxt   = (w_next == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_begin_dma <= 1'b0;
      r_bg        <= 1'b0;
      r_cpu_stall <= 1'b0;
      r_end_irq   <= 1'b0;
    end else begin
      r_begin_dma <= w_begin_nxt;
      r_bg        <= w_bg_nxt;
      r_cpu_stall <= w_bg_nxt;
      r_end_irq   <= w_end_nxt;
    end
  end

  // One queued request at most; IDLE consumes it on the edge that launches START.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  r_pending <= 1'b0;
    else if (r_state == S_IDLE) r_pending <= 1'b0;
    else if (dev_irq)           r_pending <= 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_grant_cnt   <= '0;
      r_busy_cycles <= '0;
    end else begin
      if (w_grant)
        r_grant_cnt <= '0;
      else if (r_state == S_GRANTED)
        r_grant_cnt <= sat_inc(r_grant_cnt);
      if (w_release)
        r_busy_cycles <= sat_inc(r_grant_cnt);
      else if (w_abort)
        r_busy_cycles <= '0;
    end
  end

  assign begin_dma      = r_begin_dma;
  assign bg             = r_bg;
  assign cpu_stall      = r_cpu_stall;
  assign dma_end_irq    = r_end_irq;
  assign busy_cycles    = r_busy_cycles;
  assign length         = WORD_SIZE'(DMA_LENGTH);
  assign target_address = DMA_TARGET;

endmodule

// File: doc/dma_bus_arbiter.md
Name: dma_bus_arbiter

Overview:
- Upstream companion of the DMA engine. Turns an external-device interrupt into a one-cycle begin_dma command with fixed length and target address.
- Runs the br/bg bus handshake against the CPU's memory-stage activity and stalls the CPU while the DMA owns the bus.
- Pulses a completion interrupt to the CPU when the DMA releases br.

Parameters:
- WORD_SIZE, 16: data/address width.
- DMA_LENGTH, 12: word count driven on length.
- DMA_TARGET, 16'h01F4: base address driven on target_address.
- WDOG_CYCLES, 64: watchdog limit, used only with the optional feature.

Ports:
- clk  in  1  clock, all state on posedge
- reset  in  1  asynchronous active-high reset
- dev_irq  in  1  external device has data ready (level, sampled)
- cpu_mem_busy  in  1  CPU memory stage is using the bus this cycle
- br  in  1  bus request from DMA engine
- begin_dma  out  1  one-cycle DMA start command
- length  out  WORD_SIZE  transfer length, constant DMA_LENGTH
- target_address  out  WORD_SIZE  transfer base, constant DMA_TARGET
- bg  out  1  bus grant to DMA engine
- cpu_stall  out  1  freeze CPU memory access
- dma_end_irq  out  1  one-cycle completion interrupt to CPU
- dma_error  out  1  one-cycle abort pulse (watchdog feature only)
- busy_cycles  out  WORD_SIZE  bg-high cycle count of last completed transfer

Behaviour:
- All outputs are registered. length and target_address are continuous constants.
- Reset, asynchronous, any state: state=IDLE; begin_dma=0, bg=0, cpu_stall=0, dma_end_irq=0, dma_error=0, busy_cycles=0; pending=0; counters=0.
- IDLE -> START when dev_irq=1 or pending=1 at the edge; pending clears on that edge.
- START: begin_dma=1 for exactly one cycle, the cycle after dev_irq was sampled. Then go to WAIT_BR.
- WAIT_BR: stay until br=1 and cpu_mem_busy=0 at the same edge. On that edge: bg<=1, cpu_stall<=1, grant counter<=0, go to GRANTED.
  - If br=1 and cpu_mem_busy=1: hold; bg stays 0. The CPU's in-flight access always finishes first.
- GRANTED: bg=1, cpu_stall=1; grant counter increments by 1 each cycle, saturating at all-ones.
  - When br=0 is sampled: bg<=0, cpu_stall<=0, busy_cycles<=grant counter+1 (saturating), go to DONE.
- DONE: dma_end_irq=1 for exactly one cycle, then IDLE.
- dev_irq=1 in any state other than IDLE sets pending. Only one request is queued; further requests merge into it. Pending is served on the edge DONE->IDLE->START, giving a 1-cycle IDLE gap.
- Simultaneous br drop and dev_irq in GRANTED: release the bus as normal, set pending.
- bg never rises while cpu_mem_busy=1 is sampled. cpu_stall equals bg on every cycle.
- br=1 seen in IDLE or START is ignored, no grant.
- Reset mid-GRANTED drops bg and cpu_stall asynchronously and discards pending.

Optional Feature:
- Macro: DMA_ARB_WATCHDOG_EN.
- Enabled: one counter runs in WAIT_BR and in GRANTED.
  - When it reaches WDOG_CYCLES in either state: bg<=0, cpu_stall<=0, dma_error pulses 1 cycle, busy_cycles<=0, go to IDLE.
  - No dma_end_irq is raised on abort. pending is kept.
- Disabled: no counter logic; dma_error is tied 0; a stuck br holds the CPU indefinitely.

Test Plan:
- Reset, then dev_irq pulse at cycle 2, br rises at cycle 4, cpu_mem_busy=0, br held 12 cycles -> begin_dma high cycle 3 only; bg/cpu_stall high cycles 5-16; dma_end_irq high cycle 17; busy_cycles=12.
- br=1 while cpu_mem_busy=1 for 3 cycles -> bg stays 0 for those 3 cycles and rises on the first edge with cpu_mem_busy=0.
- dev_irq during GRANTED -> after dma_end_irq, second begin_dma one cycle after returning to IDLE; exactly 2 begin_dma pulses total.
- Assert reset while bg=1 -> bg, cpu_stall and pending go 0 immediately; no dma_end_irq and no further begin_dma.
- br=1 asserted in IDLE with no dev_irq -> bg remains 0 for 20 cycles.
- Watchdog (DMA_ARB_WATCHDOG_EN, WDOG_CYCLES=64): br never drops -> bg=0 and dma_error=1 exactly 64 cycles after bg rose; no dma_end_irq; busy_cycles=0.
